// File: rtl/demux_pkg.sv
// Shared types and helpers for the round-robin demux scheduler.
package demux_pkg;

  localparam int NCH = 4;

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Next enabled channel after cur, searching cur+1, +2, +3, then cur itself.
  // Returns cur unchanged when the mask is empty.
  function automatic logic [1:0] next_en_ch(input logic [1:0] cur,
                                            input logic [NCH-1:0] mask);
    logic [1:0] idx;
    logic       hit;
    next_en_ch = cur;
    hit        = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = cur + i[1:0];
      if (!hit && mask[idx]) begin
        next_en_ch = idx;
        hit        = 1'b1;
      end else begin
        hit = hit;
      end
    end
  endfunction

endpackage

// File: rtl/demux_rr_pick.sv
// Combinational next-enabled-channel finder shared by burst rotation,
// timeout rotation and the SEEK walk.
module demux_rr_pick
  import demux_pkg::*;
(
  input  logic [1:0]     cur_i,
  input  logic [NCH-1:0] mask_i,
  output logic [1:0]     next_o,
  output logic           found_o
);

  // Search order starts one past the current channel and wraps back to it.
  always_comb begin
    next_o  = next_en_ch(cur_i, mask_i);
    found_o = |mask_i;
  end

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler in front of a 1-to-4 demux: takes one valid/ready
// word stream, holds each word in an output register and steers it to a
// channel with burst rotation, an enable mask and a stall timeout.
module demux_rr_sched
  import demux_pkg::*;
#(
  parameter int DW      = 8,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [3:0]    ch_en,
  output logic [1:0]    sel,
  output logic [DW-1:0] out_data,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic          drop,
  output logic          busy
);

  // Counter widths never collapse to zero bits for degenerate parameters.
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e        state_q, state_d;
  logic [1:0]    cur_ch_q, cur_ch_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [1:0]    sel_q, sel_d;
  logic [DW-1:0] data_q, data_d;
  logic [3:0]    valid_q, valid_d;
  logic          drop_q, drop_d;
  logic          busy_q, busy_d;

  logic [1:0]    nxt_ch_s;
  logic          any_en_s;
  logic          accept_s;

  demux_rr_pick u_pick (
    .cur_i   (cur_ch_q),
    .mask_i  (ch_en),
    .next_o  (nxt_ch_s),
    .found_o (any_en_s)
  );

  // Upstream ready: open in RUN on an enabled channel, and in HOLD only when
  // the held word leaves this cycle so back-to-back words need no bubble.
  always_comb begin
    case (state_q)
      RUN:     in_ready = ch_en[cur_ch_q];
      HOLD:    in_ready = out_ready[sel_q] & ch_en[cur_ch_q];
      default: in_ready = 1'b0;
    endcase
  end

  assign accept_s = in_valid & in_ready;

  // Next-state, counter and output-register update for the SEEK/RUN/HOLD FSM.
  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    burst_d  = burst_q;
    stall_d  = stall_q;
    sel_d    = sel_q;
    data_d   = data_q;
    valid_d  = valid_q;
    drop_d   = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      SEEK: begin
        burst_d = '0;
        if (ch_en[cur_ch_q]) begin
          state_d = RUN;
        end else if (any_en_s) begin
          cur_ch_d = nxt_ch_s;
          state_d  = RUN;
        end else begin
          state_d = SEEK;
        end
      end

      RUN: begin
        if (!accept_s && !ch_en[cur_ch_q]) begin
          state_d = SEEK;
        end else begin
          state_d = RUN;
        end
      end

      HOLD: begin
        if (out_ready[sel_q]) begin
          // Held word leaves; a simultaneous accept is handled below.
          busy_d  = 1'b0;
          valid_d = 4'b0000;
          stall_d = '0;
          state_d = ch_en[cur_ch_q] ? RUN : SEEK;
        end else if ((TIMEOUT > 0) && (stall_q == STALL_LAST)) begin
          // Give up on the stuck channel and move the rotation past it.
          busy_d   = 1'b0;
          valid_d  = 4'b0000;
          drop_d   = 1'b1;
          stall_d  = '0;
          burst_d  = '0;
          cur_ch_d = nxt_ch_s;
          state_d  = any_en_s ? RUN : SEEK;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end

      default: begin
        state_d = SEEK;
      end
    endcase

    // A new word always lands on the current channel and counts toward its burst.
    if (accept_s) begin
      data_d  = in_data;
      sel_d   = cur_ch_q;
      valid_d = 4'b0001 << cur_ch_q;
      busy_d  = 1'b1;
      stall_d = '0;
      state_d = HOLD;
      if (burst_q == BURST_LAST) begin
        burst_d  = '0;
        cur_ch_d = nxt_ch_s;
      end else begin
        burst_d = burst_q + BW'(1);
      end
    end else begin
      data_d = data_d;
    end
  end

  // State and output registers; reset discards any held word without a drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEEK;
      cur_ch_q <= 2'd0;
      burst_q  <= '0;
      stall_q  <= '0;
      sel_q    <= 2'd0;
      data_q   <= '0;
      valid_q  <= 4'b0000;
      drop_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      burst_q  <= burst_d;
      stall_q  <= stall_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
      busy_q   <= busy_d;
    end
  end

  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign drop      = drop_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed, table-driven bench for demux_rr_sched (DW=8, BURST=4, TIMEOUT=16).
module tb_demux_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] ch_en;
  logic [1:0] sel;
  logic [7:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic       drop;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] en;
    logic [7:0] din;
    logic [1:0] sel;
  } vec_t;

  vec_t tbl[50];

  demux_rr_sched #(.DW(8), .BURST(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ch_en     (ch_en),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop      (drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " sel"},       sel, 0);
    check({tag, " out_data"},  out_data, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " drop"},      drop, 0);
    check({tag, " busy"},      busy, 0);
    check({tag, " in_ready"},  in_ready, 0);
  endtask

  task automatic do_reset(input logic [3:0] en);
    in_valid  = 1'b0;
    in_data   = 8'h00;
    ch_en     = en;
    out_ready = 4'hF;
    rst_n     = 1'b0;
    #1;
    check_reset_vals("reset");
    cyc();
    rst_n = 1'b1;
  endtask

  // Apply one word per cycle from the table and check it lands one cycle later.
  task automatic run_vec(input int first, input int last);
    logic [3:0] oh;
    for (int i = first; i <= last; i++) begin
      ch_en    = tbl[i].en;
      in_data  = tbl[i].din;
      in_valid = 1'b1;
      #1;
      check("in_ready", in_ready, 1);
      cyc();
      oh = 4'b0001 << tbl[i].sel;
      check("sel",       sel, tbl[i].sel);
      check("out_data",  out_data, tbl[i].din);
      check("out_valid", out_valid, oh);
      check("busy",      busy, 1);
      check("drop",      drop, 0);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    cyc();
    check("drain busy", busy, 0);
    check("drain out_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic got;

    // Full-rate rotation with all channels: sel 0x4,1x4,2x4,3x4.
    for (int i = 0; i < 16; i++) tbl[i] = '{4'hF, 8'(i), 2'(i / 4)};
    // Mask 1010: channels 1 and 3 only.
    for (int i = 0; i < 8; i++) tbl[16 + i] = '{4'hA, 8'(8'h20 + i), (i < 4) ? 2'd1 : 2'd3};
    // Timeout run: eight words to ch0/ch1, the ninth lands on stalled ch2.
    for (int i = 0; i < 9; i++) tbl[24 + i] = '{4'hF, 8'(8'h40 + i), 2'(i / 4)};
    // After the drop: burst restarts on ch3 (0x49 by hand), then rotates to ch0.
    tbl[33] = '{4'hF, 8'h4A, 2'd3};
    tbl[34] = '{4'hF, 8'h4B, 2'd3};
    tbl[35] = '{4'hF, 8'h4C, 2'd3};
    tbl[36] = '{4'hF, 8'h4D, 2'd0};
    // Mid-burst disable: two words on ch0, then ch0 is masked off.
    tbl[37] = '{4'hF, 8'h60, 2'd0};
    tbl[38] = '{4'hF, 8'h61, 2'd0};
    tbl[39] = '{4'hE, 8'h62, 2'd1};
    tbl[40] = '{4'hE, 8'h63, 2'd1};
    tbl[41] = '{4'hE, 8'h64, 2'd1};
    tbl[42] = '{4'hE, 8'h65, 2'd1};
    tbl[43] = '{4'hE, 8'h66, 2'd2};
    // Reset-during-hold: fifth word held on ch1.
    for (int i = 0; i < 5; i++) tbl[44 + i] = '{4'hF, 8'(8'h80 + i), (i < 4) ? 2'd0 : 2'd1};
    tbl[49] = '{4'hF, 8'h90, 2'd0};

    // Test 1: full rate, all enabled.
    do_reset(4'hF);
    in_valid = 1'b1;
    in_data  = tbl[0].din;
    #1;
    check("t1 seek bubble", in_ready, 0);
    cyc();
    run_vec(0, 15);
    drain();

    // Test 2: mask 1010, one SEEK cycle after reset.
    do_reset(4'hA);
    in_valid = 1'b1;
    in_data  = tbl[16].din;
    #1;
    check("t2 seek bubble", in_ready, 0);
    cyc();
    run_vec(16, 23);
    drain();

    // Test 3: ch2 never ready, word dropped after 16 held cycles.
    do_reset(4'hF);
    out_ready = 4'b1011;
    cyc();
    run_vec(24, 32);
    in_data  = 8'h49;
    in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      check("t3 held valid", out_valid, 4'b0100);
      check("t3 held drop", drop, 0);
      check("t3 held in_ready", in_ready, 0);
      cyc();
    end
    #1;
    check("t3 drop pulse", drop, 1);
    check("t3 drop valid", out_valid, 0);
    check("t3 drop busy", busy, 0);
    check("t3 drop in_ready", in_ready, 1);
    cyc();
    check("t3 post drop", drop, 0);
    check("t3 next sel", sel, 3);
    check("t3 next data", out_data, 8'h49);
    run_vec(33, 36);
    drain();

    // Test 4: clear ch_en[0] after two words of a burst.
    do_reset(4'hF);
    cyc();
    run_vec(37, 38);
    ch_en    = 4'hE;
    in_data  = 8'h62;
    in_valid = 1'b1;
    #1;
    check("t4 hold in_ready", in_ready, 0);
    check("t4 hold valid", out_valid, 4'b0001);
    check("t4 hold sel", sel, 0);
    cyc();
    check("t4 seek in_ready", in_ready, 0);
    check("t4 seek busy", busy, 0);
    cyc();
    check("t4 run in_ready", in_ready, 1);
    run_vec(39, 43);
    drain();

    // Test 5: empty mask stalls indefinitely, then ch0 resumes.
    ch_en    = 4'h0;
    in_data  = 8'h70;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      check("t5 stall in_ready", in_ready, 0);
      check("t5 stall valid", out_valid, 0);
      cyc();
    end
    ch_en = 4'h1;
    got   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    check("t5 resume", got, 1);
    cyc();
    check("t5 sel", sel, 0);
    check("t5 data", out_data, 8'h70);
    check("t5 valid", out_valid, 4'b0001);
    drain();

    // Test 6: asynchronous reset while a word is held on ch1.
    do_reset(4'hF);
    out_ready = 4'b1101;
    cyc();
    run_vec(44, 48);
    in_valid = 1'b0;
    #1;
    check("t6 held busy", busy, 1);
    check("t6 held sel", sel, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6 async");
    cyc();
    check("t6 no drop", drop, 0);
    rst_n     = 1'b1;
    out_ready = 4'hF;
    cyc();
    run_vec(49, 49);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux_rr_sched.md
# demux_rr_sched

Round-robin scheduler that feeds the 1-to-4 demux. It accepts a single valid/ready word stream and assigns each word to one of four destination channels. It generates the 2-bit demux select plus per-channel valid strobes, with burst-length rotation, a channel enable mask and a stall timeout. It sits directly upstream of the demux and owns all sequencing of the select lines.

## Interface
- DW, 8, data width
- BURST, 4, words sent to one channel before rotating (>=1)
- TIMEOUT, 16, max cycles a held word waits for out_ready before drop; 0 disables
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream word valid
- in_data  in  DW  upstream word
- in_ready  out  1  word accepted when in_valid && in_ready at clk edge
- ch_en  in  4  channel enable mask; bit k enables channel k
- sel  out  2  demux select; a=sel[1], b=sel[0]; sel=0→dout, 1→cout, 2→bout, 3→aout
- out_data  out  DW  held word, shared by all channels
- out_valid  out  4  one-hot, bit sel set while a word is held; 0 when empty
- out_ready  in  4  per-channel ready; transfer when out_valid[k] && out_ready[k]
- drop  out  1  one-cycle pulse when a held word is discarded by timeout
- busy  out  1  word held in output register

## Operation
- FSM states:
  - SEEK: no word held, cur_ch disabled.
  - RUN: no word held, cur_ch enabled.
  - HOLD: word held.
- RUN:
  - in_ready=1.
  - On accept: load out_data, set sel=cur_ch, and go to HOLD.
  - burst_cnt increments. At BURST-1, burst_cnt returns to 0 and cur_ch advances to the next enabled channel (search cur_ch+1, +2, +3, +0 mod 4).
- HOLD:
  - in_ready=out_ready[sel] && ch_en[cur_ch]. This allows back-to-back transfer with no bubble.
  - On transfer with no new accept: go to RUN, or to SEEK if ch_en[cur_ch]=0.
  - On transfer plus accept: stay in HOLD with the new word and sel=cur_ch.
- SEEK:
  - in_ready=0. Each cycle cur_ch advances to the next enabled channel and burst_cnt clears.
  - Go to RUN when ch_en[cur_ch]=1. This costs a 1-cycle bubble per disable.
- ch_en=0: remain in SEEK and stall indefinitely. No output activity.
- ch_en changes mid-burst:
  - A word already held keeps its sel.
  - If ch_en[cur_ch] drops, the next load goes through SEEK.
- Timeout (TIMEOUT>0):
  - stall_cnt counts HOLD cycles with out_ready[sel]=0. It clears on transfer and on load.
  - When stall_cnt reaches TIMEOUT-1 and out_ready[sel] is still 0: clear out_valid, pulse drop, and force rotation (cur_ch→next enabled, burst_cnt=0). Go to RUN or SEEK; no new accept that cycle.
- Width rules: burst_cnt is clog2(BURST) bits; stall_cnt is clog2(TIMEOUT+1) bits. Both saturate-free because they are bounded by their compare values.

## Timing
- Reset values: sel=0, out_data=0, out_valid=0, drop=0, busy=0, in_ready=0, cur_ch=0, burst_cnt=0, stall_cnt=0, state=SEEK.
- First in_ready rises one cycle after reset release if ch_en[0]=1. Otherwise it rises after a SEEK walk of up to 3 cycles.
- Latency: a word accepted at edge N is on out_data/out_valid after edge N (1 cycle).
- Throughput: 1 word/cycle while the target channel stays ready and enabled.
- Registered outputs: sel, out_data, out_valid, drop, busy.
- Combinational outputs: in_ready only (from state, out_ready, ch_en).
- Reset asserted mid-HOLD: the word is lost, all outputs return to reset values immediately, and there is no drop pulse.

## Structure
- Shared package demux_pkg:
  - State enum {SEEK, RUN, HOLD}.
  - NCH=4 constant.
  - Function next_en_ch(cur, mask) returning the next enabled index after cur, wrapping.
- One sub-module, demux_rr_pick: combinational 4-way next-enabled-channel finder, used by both rotation and SEEK.
- The demux itself is instantiated by the parent, not inside this block.

## Test plan
- Reset, ch_en=4'hF, all out_ready=1, 16 words 0x00..0x0F at full rate:
  - sel sequence is 0×4, 1×4, 2×4, 3×4.
  - out_data matches input order, delayed 1 cycle.
  - No bubbles.
- ch_en=4'b1010, 8 words:
  - Words go to channels 1 and 3 only, 4 each.
  - Exactly one SEEK bubble after reset.
- Channel 2 out_ready=0, TIMEOUT=16:
  - The held word drops after 16 cycles and drop pulses once.
  - The next word goes to channel 3 and burst_cnt=0.
- Clear ch_en[cur_ch] mid-burst (after 2 of 4 words):
  - The held word still completes on the old sel.
  - There is one-cycle in_ready=0, then rotation to the next enabled channel.
- ch_en=0 with in_valid=1 for 20 cycles:
  - in_ready=0 and out_valid=0 throughout.
  - Set ch_en=4'h1: accept resumes within 4 cycles on sel=0.
- Assert rst_n=0 during HOLD:
  - All outputs return to reset values asynchronously, with no drop pulse.
  - Post-reset rotation restarts at channel 0.
